// File: rtl/uart_tx_serializer.sv
// Buffered UART transmitter: byte FIFO feeding a start/8N/parity/stop serializer paced by intx.
// Define UART_TX_PARITY_EN for 11-bit frames with even parity; otherwise 10-bit frames.
module uart_tx_serializer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               intx,
    input  logic [7:0]                         tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               tx,
    output logic [10:0]                        out_tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif
    localparam logic [2:0] StStop   = 3'd4;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            full, empty, push, pop;

    logic [2:0]      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            tx_q, tx_d;
    logic [10:0]     out_tx_q, out_tx_d;
    logic [3:0]      bit_idx;

    function automatic logic [10:0] build_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    assign full     = (count_q == CntW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push     = tx_valid && !full;
    assign bit_idx  = {1'b0, bit_cnt_q} + 4'd2;

    assign tx_ready   = !full;
    assign tx         = tx_q;
    assign out_tx     = out_tx_q;
    assign busy       = (state_q != StIdle);
    assign fifo_count = count_q;

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        out_tx_d  = out_tx_q;
        pop       = 1'b0;
        if (intx) begin
            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        pop      = 1'b1;
                        out_tx_d = build_frame(mem[rd_ptr_q]);
                        tx_d     = 1'b0;
                        state_d  = StStart;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
                StStart: begin
                    tx_d      = out_tx_q[1];
                    bit_cnt_d = 3'd0;
                    state_d   = StData;
                end
                StData: begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = out_tx_q[9];
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        tx_d      = out_tx_q[bit_idx];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
`endif
                StStop: begin
                    // Chain straight into the next frame with no idle bit in between.
                    if (!empty) begin
                        pop      = 1'b1;
                        out_tx_d = build_frame(mem[rd_ptr_q]);
                        tx_d     = 1'b0;
                        state_d  = StStart;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            tx_q      <= 1'b1;
            out_tx_q  <= 11'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            out_tx_q  <= out_tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: per-cycle frame/queue model, vector table, corner sequences.
module tb_uart_tx_serializer;

    localparam int unsigned DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int FL     = 11;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int FL     = 10;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          intx;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx;
    logic [10:0]   out_tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    uart_tx_serializer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .intx       (intx),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .out_tx     (out_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: queued bytes plus the frame word being walked one bit per tick.
    logic [7:0]  fq [$];
    bit          m_active;
    int          m_pos;
    logic [10:0] m_word;

    // Line-side observers.
    int          tick_period;
    int          phase;
    int          rx_pos;
    logic [7:0]  rx_byte;
    logic [7:0]  rx_q [$];
    int          rx_err;
    logic [10:0] cap;
    int          cap_n;
    int          busy_cyc;
    int          busy_falls;
    logic        prev_busy;

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = (ones % 2) == 1;
        return {1'b1, PAR_EN ? p : 1'b1, d, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_word   = 11'd0;
    endtask

    task automatic load_next();
        m_word   = frame_of(fq.pop_front());
        m_pos    = 0;
        m_active = 1'b1;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic tk);
        bit can_push;
        can_push = fq.size() < DEPTH;
        if (tk) begin
            if (!m_active) begin
                if (fq.size() > 0) load_next();
            end else if (m_pos < FL - 1) begin
                m_pos++;
            end else if (fq.size() > 0) begin
                load_next();
            end else begin
                m_active = 1'b0;
            end
        end
        if (v && can_push) fq.push_back(d);
    endtask

    task automatic check_cycle(input logic tk);
        logic           exp_tx;
        logic [CW+13:0] got, exp;
        exp_tx = m_active ? m_word[m_pos] : 1'b1;
        exp = {exp_tx, m_active, fq.size() < DEPTH, CW'(fq.size()), m_word};
        got = {tx, busy, tx_ready, fifo_count, out_tx};
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL cycle t=%0t: got tx=%b busy=%b ready=%b count=%0d out_tx=%h, expected tx=%b busy=%b ready=%b count=%0d out_tx=%h",
                     $time, tx, busy, tx_ready, fifo_count, out_tx,
                     exp_tx, m_active, fq.size() < DEPTH, fq.size(), m_word);
        end
        if (busy === 1'b1) busy_cyc++;
        if (prev_busy === 1'b1 && busy === 1'b0) busy_falls++;
        prev_busy = busy;
        if (tk) begin
            if (cap_n < 11 && (cap_n > 0 || tx === 1'b0)) begin
                cap[cap_n] = tx;
                cap_n++;
            end
            if (rx_pos == 0) begin
                if (tx === 1'b0) rx_pos = 1;
            end else if (rx_pos <= 8) begin
                rx_byte[rx_pos-1] = tx;
                rx_pos++;
            end else if (rx_pos < FL - 1) begin
                if (tx !== ^rx_byte) rx_err++;
                rx_pos++;
            end else begin
                if (tx !== 1'b1) rx_err++;
                rx_q.push_back(rx_byte);
                rx_pos = 0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        logic tk;
        tk = (tick_period != 0) && (phase == tick_period - 1);
        tx_valid = v;
        tx_data  = d;
        intx     = tk;
        @(posedge clk);
        model_edge(v, d, tk);
        #1;
        check_cycle(tk);
        if (tick_period != 0) phase = (phase + 1) % tick_period;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        tx_valid = 1'b0;
        intx     = 1'b0;
        model_reset();
        rx_pos     = 0;
        rx_q.delete();
        rx_err     = 0;
        cap        = 11'd0;
        cap_n      = 0;
        phase      = 0;
        #1;
        check_cycle(1'b0);
        busy_cyc   = 0;
        busy_falls = 0;
        prev_busy  = 1'b0;
        #2;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  data;
        int          period;
        logic [10:0] word_par;
        logic [10:0] word_np;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp_word;
        int          guard;

        vecs[0] = '{8'hA5, 4, 11'h54A, 11'h74A};
        vecs[1] = '{8'h07, 1, 11'h60E, 11'h60E};
        vecs[2] = '{8'h00, 2, 11'h400, 11'h600};
        vecs[3] = '{8'hFF, 3, 11'h5FE, 11'h7FE};
        vecs[4] = '{8'h01, 5, 11'h602, 11'h602};
        vecs[5] = '{8'h80, 2, 11'h700, 11'h700};

        reset       = 1'b0;
        intx        = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        tick_period = 0;
        #1;
        do_reset();
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_out_tx", {21'd0, out_tx}, 32'd0);

        // Single-frame vectors.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            tick_period = vecs[i].period;
            exp_word    = PAR_EN ? vecs[i].word_par : vecs[i].word_np;
            step(1'b1, vecs[i].data);
            repeat ((FL + 3) * vecs[i].period + 2) step(1'b0, 8'h00);
            check("frame_bits", {21'd0, cap}, {21'd0, exp_word});
            check("frame_out_tx", {21'd0, out_tx}, {21'd0, exp_word});
            check("busy_len", busy_cyc, FL * vecs[i].period);
        end

        // Back-to-back frames: busy must stay high across the seam.
        do_reset();
        tick_period = 3;
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        repeat ((2 * FL + 3) * 3) step(1'b0, 8'h00);
        check("b2b_busy_len", busy_cyc, 2 * FL * 3);
        check("b2b_busy_falls", busy_falls, 1);
        check("b2b_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_byte0", {24'd0, rx_q[0]}, 32'h00);
            check("b2b_byte1", {24'd0, rx_q[1]}, 32'hFF);
        end

        // Fill the FIFO with intx held low, then drain.
        do_reset();
        tick_period = 0;
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        step(1'b1, 8'h44);
        check("full_count", {29'd0, 3'(fifo_count)}, 32'd4);
        check("full_ready", {31'd0, tx_ready}, 32'd0);
        step(1'b1, 8'h55);
        tick_period = 2;
        phase       = 0;
        guard       = 0;
        while (busy !== 1'b1 && guard < 10) begin
            step(1'b0, 8'h00);
            guard++;
        end
        check("first_pop_ready", {31'd0, tx_ready}, 32'd1);
        check("first_pop_count", {29'd0, 3'(fifo_count)}, 32'd3);
        repeat ((4 * FL + 6) * 2) step(1'b0, 8'h00);
        check("full_rx_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("full_rx_byte", {24'd0, (rx_q.size() > i) ? rx_q[i] : 8'hxx},
                  32'h11 * (i + 1));
        end

        // Ten bytes through the wrapping pointers at mixed tick and push rates.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            tick_period = 1 + (k % 4);
            phase       = 0;
            guard       = 0;
            while (tx_ready !== 1'b1 && guard < 500) begin
                step(1'b0, 8'h00);
                guard++;
            end
            step(1'b1, 8'(k));
            repeat ($urandom_range(0, 20)) step(1'b0, 8'h00);
        end
        guard = 0;
        while (rx_q.size() < 10 && guard < 2000) begin
            step(1'b0, 8'h00);
            guard++;
        end
        check("wrap_rx_count", rx_q.size(), 10);
        check("wrap_rx_err", rx_err, 0);
        for (int i = 0; i < 10; i++) begin
            check("wrap_byte", {24'd0, (rx_q.size() > i) ? rx_q[i] : 8'hxx}, i + 1);
        end

        // Reset in the middle of DATA bit 3 with two bytes still queued.
        do_reset();
        tick_period = 2;
        step(1'b1, 8'hAA);
        step(1'b1, 8'hBB);
        step(1'b1, 8'hCC);
        guard = 0;
        while (cap_n < 5 && guard < 100) begin
            step(1'b0, 8'h00);
            guard++;
        end
        check("mid_fifo_before", {29'd0, 3'(fifo_count)}, 32'd2);
        do_reset();
        check("mid_tx", {31'd0, tx}, 32'd1);
        check("mid_count", {29'd0, 3'(fifo_count)}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        tick_period = 2;
        repeat (40) step(1'b0, 8'h00);
        check("mid_no_restart", busy_cyc, 0);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                tick_period = $urandom_range(1, 6);
                phase       = 0;
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 2) == 0, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmitter that buffers bytes in a small FIFO and serializes each one onto a single line as an 11-bit frame: start, 8 data bits LSB first, even parity, stop. Bit timing comes entirely from the `intx` tick produced by the baud generator. The block sits between the host-side byte producer and the UART line. Its frame layout matches what the team's UART receiver decodes.

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO depth; power of 2, minimum 2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `intx`  in  1  baud tick from the baud generator; single-cycle pulse per bit period.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  producer has `tx_data` available.
- `tx_ready`  out  1  FIFO can accept a byte; equals not full.
- `tx`  out  1  serial line; idles high.
- `out_tx`  out  11  frame currently being shifted: bit 0 start, bits 8:1 data, bit 9 parity, bit 10 stop.
- `busy`  out  1  a frame is in progress (state is not IDLE).
- `fifo_count`  out  `$clog2(FIFO_DEPTH+1)`  number of bytes buffered.

## Operation
- Push:
  - A byte is written to the FIFO on a rising `clk` when `tx_valid && tx_ready`.
  - `tx_ready` is combinational `!full`.
  - A push while full cannot occur; data is held by the producer.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- The FSM advances only on cycles where `intx=1`. On all other cycles, state, `tx` and the bit counter hold.
- IDLE:
  - `intx` with FIFO non-empty: pop the head byte d.
  - Load `out_tx <= {1'b1, ^d, d, 1'b0}`.
  - Set `tx <= 0` and go to START.
  - Otherwise `tx` stays 1.
- START, on `intx`: `tx <= out_tx[1]`, `bit_cnt <= 0`, go to DATA.
- DATA, on `intx`:
  - If `bit_cnt == 7`: `tx <= out_tx[9]`, go to PARITY.
  - Else: `tx <= out_tx[bit_cnt+2]`, `bit_cnt <= bit_cnt+1`.
- PARITY, on `intx`: `tx <= 1`, go to STOP.
- STOP, on `intx`:
  - FIFO non-empty: pop the next byte, load `out_tx`, `tx <= 0`, go to START (back-to-back frames, no idle bit).
  - Else: `tx` stays 1, go to IDLE.
- Parity is even: data bits plus parity bit contain an even number of 1s.
- `fifo_count`:
  - Incremented on push, decremented on pop.
  - Unchanged when a push and a pop occur in the same cycle.
- Simultaneous push and pop on a full FIFO is impossible, because `tx_ready=0`.
- Simultaneous push and pop on an empty FIFO: no pop occurs. The pop requires non-empty at the cycle edge, so the new byte is popped on the next `intx`.
- Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Full/empty are derived from `fifo_count`.

## Timing
- Reset values:
  - `tx=1`, `out_tx=0`, `busy=0`, `fifo_count=0`, `tx_ready=1`.
  - State IDLE, `bit_cnt=0`, FIFO pointers 0.
- Reset mid-frame: all of the above apply immediately (asynchronously). The FIFO contents are discarded and the partial frame is abandoned with `tx` high.
- Latency: a byte pushed at edge t into an empty idle block appears as the start bit on `tx` one cycle after the first `intx` at or after edge t+1.
- Each bit is held for exactly one tick interval. A frame occupies 11 tick intervals (10 without parity).
- `busy` rises in the same cycle `tx` falls for the start bit. It falls in the cycle STOP exits to IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is present.
  - 11-bit frame, `out_tx[9]` = even parity.
- `UART_TX_PARITY_EN` undefined:
  - PARITY state is removed; DATA with `bit_cnt==7` on `intx` sets `tx <= 1` and goes to STOP.
  - 10-bit frame, `out_tx[9]=1` and `out_tx[10]=1`.

## Test plan
- Single byte: `intx` every 4 clk, push 8'hA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 clk. Parity bit 0. `busy` high for 44 clk.
- Parity: push 8'h07 → parity bit 1 and `out_tx = 11'h60E`. With `UART_TX_PARITY_EN` undefined → 10 bits sent, no parity bit.
- Back-to-back: push 8'h00 and 8'hFF in consecutive cycles → second start bit directly follows first stop bit, 22 tick intervals total, `busy` never drops.
- FIFO full: with `intx` held low, push 4 bytes → `fifo_count=4`, `tx_ready=0`. Enable `intx` → bytes sent in order. `tx_ready` returns 1 on the first pop.
- Wrap-around: push and send 10 bytes 8'h01..8'h0A at mixed rates → all are received in order by the team's receiver, with no error flagged.
- Reset mid-frame: assert `reset` during DATA bit 3 with 2 bytes queued → `tx=1`, `fifo_count=0`, `busy=0` immediately. No further frames start after deassertion until a new push.
